// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the 4x4 Vedic-multiplier MAC datapath.
// Accepts a job (start + len), streams len operand pairs through the external
// combinational multiplier, accumulates the products and offers the
// dot-product result to a consumer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Operand side: in_valid (producer) / in_ready (this block). Result
// side: res_valid (this block) / res_ready (consumer). A valid source keeps
// its data stable until the transfer; res and ovf stay frozen while
// res_valid is 1.
module mac_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8,
    parameter int LEN_W  = 4,
    parameter int SAT    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    input  logic [2*DATA_W-1:0] mul_p,
    output logic [ACC_W-1:0]    res,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                ovf,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_upd;
    logic               w_beat;

    // The multiplier sees the pins in every state; only RUN beats use mul_p.
    assign mul_a = a;
    assign mul_b = b;

    // Outputs are pure decodes of the registered state.
    assign in_ready  = (r_state == S_RUN);
    assign res_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign res       = r_acc;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

    assign w_beat = in_valid & in_ready;

    // One extra bit exposes the carry-out; with saturation the clamp is
    // sticky because any further carry (or a zero product) keeps all-ones.
    always_comb begin
        w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(mul_p);
        w_acc_upd = w_sum[ACC_W-1:0];
        if ((SAT != 0) && w_sum[ACC_W]) begin
            w_acc_upd = '1;
        end
    end

    // Next-state and datapath-update decode; abort has priority over a beat.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_cnt_nxt   = len;
                    w_state_nxt = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_beat) begin
                    w_acc_nxt = w_acc_upd;
                    w_ovf_nxt = r_ovf | w_sum[ACC_W];
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

endmodule
